// File: rtl/pwm_pkg.sv
// Shared types and build options for the PWM RGB driver.
// Define PWM_INVERT_EN to build active-low outputs for common-anode LEDs.
package pwm_pkg;

    typedef enum logic {S_SYNC, S_RUN} state_t;

    localparam int unsigned PWM_N_DEFAULT        = 8;
    localparam int unsigned PWM_CHANNELS_DEFAULT = 3;

`ifdef PWM_INVERT_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty/enable shadows plus the registered compare output.
// Output polarity follows OUT_INV from pwm_pkg (set by PWM_INVERT_EN).
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int N = PWM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         run_i,
    input  logic [N-1:0] cnt_i,
    input  logic [N-1:0] duty_i,
    input  logic         en_i,
    output logic         out_o
);

    logic [N-1:0] duty_q, duty_d;
    logic         en_q, en_d;
    logic         out_q, out_d;

    // run_i and cnt_i are next-state values, so out_q lines up with cnt_q.
    always_comb begin
        duty_d = load_i ? duty_i : duty_q;
        en_d   = load_i ? en_i   : en_q;
        out_d  = (run_i && en_d && (cnt_i < duty_d)) ^ OUT_INV;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            en_q   <= 1'b0;
            out_q  <= OUT_INV;
        end else begin
            duty_q <= duty_d;
            en_q   <= en_d;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/pwm_rgb_driver.sv
// Multi-channel edge-aligned PWM; counter, sync FSM and period_start pulse.
// Output polarity selectable with PWM_INVERT_EN (see pwm_pkg).
module pwm_rgb_driver
    import pwm_pkg::*;
#(
    parameter int N        = PWM_N_DEFAULT,
    parameter int CHANNELS = PWM_CHANNELS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [CHANNELS*N-1:0] duty,
    input  logic [CHANNELS-1:0]   ch_en,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_start
);

    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         ps_q, ps_d;
    logic         load;
    logic         run_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ps_d    = 1'b0;
        load    = 1'b0;
        if (ena) begin
            case (state_q)
                S_SYNC: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    load    = 1'b1;
                    ps_d    = 1'b1;
                end
                S_RUN: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        load  = 1'b1;
                        ps_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end
        run_d = (state_d == S_RUN);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(.N(N)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .load_i (load),
            .run_i  (run_d),
            .cnt_i  (cnt_d),
            .duty_i (duty[i*N +: N]),
            .en_i   (ch_en[i]),
            .out_o  (out[i])
        );
    end

    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_rgb_driver.sv
// Directed bench for pwm_rgb_driver with N=4, CHANNELS=3.
// Honours PWM_INVERT_EN when compiled with the same define as the RTL.
module tb_pwm_rgb_driver;

    localparam int N  = 4;
    localparam int CH = 3;
`ifdef PWM_INVERT_EN
    localparam logic [CH-1:0] INV = 3'b111;
`else
    localparam logic [CH-1:0] INV = 3'b000;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic [CH*N-1:0] duty;
    logic [CH-1:0]   ch_en;
    logic [CH-1:0]   out;
    logic            period_start;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: run flag, tick index within period, shadows
    logic       m_run;
    int         m_k;
    logic [N-1:0] m_duty [CH];
    logic [CH-1:0] m_en;
    logic       m_ps;

    pwm_rgb_driver #(.N(N), .CHANNELS(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .duty         (duty),
        .ch_en        (ch_en),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_k   = 0;
        m_en  = '0;
        m_ps  = 1'b0;
        for (int i = 0; i < CH; i++) m_duty[i] = '0;
    endtask

    // advance the model by one clk edge; e is the ena value at that edge
    task automatic model_step(input logic e, input logic [CH*N-1:0] d, input logic [CH-1:0] en);
        if (!e) begin
            m_ps = 1'b0;
        end else if (!m_run || m_k == (1 << N) - 1) begin
            m_run = 1'b1;
            m_k   = 0;
            m_en  = en;
            for (int i = 0; i < CH; i++) m_duty[i] = d[i*N +: N];
            m_ps  = 1'b1;
        end else begin
            m_k  = m_k + 1;
            m_ps = 1'b0;
        end
    endtask

    function automatic logic [CH-1:0] model_out();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++)
            r[i] = m_run && m_en[i] && (m_k < int'(m_duty[i]));
        return r ^ INV;
    endfunction

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; duty = '0; ch_en = '0;
        model_reset();
        tick();
        n_checks++;
        if (out !== INV) $display("FAIL reset_out: got %b exp %b", out, INV);
        else n_pass++;
        n_checks++;
        if (period_start !== 1'b0) $display("FAIL reset_ps: got %b exp 0", period_start);
        else n_pass++;
        #2 rst = 1'b0; ena = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (out !== INV) $display("FAIL sync_idle_out: got %b exp %b", out, INV);
        else n_pass++;
        n_checks++;
        if (period_start !== 1'b0) $display("FAIL sync_idle_ps: got %b exp 0", period_start);
        else n_pass++;
    endtask

    task automatic test_basic();
        int hi0 = 0;
        duty  = {4'd15, 4'd0, 4'd5};
        ch_en = 3'b111;
        ena   = 1'b1;
        for (int t = 0; t < 32; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
            if (t < 16 && ((out[0] ^ INV[0]) === 1'b1)) hi0++;
            n_checks++;
            if (out !== model_out()) $display("FAIL basic_out t=%0d: got %b exp %b", t, out, model_out());
            else n_pass++;
            n_checks++;
            if (period_start !== (t % 16 == 0)) $display("FAIL basic_ps t=%0d: got %b exp %b", t, period_start, (t % 16 == 0));
            else n_pass++;
        end
        n_checks++;
        if (hi0 !== 5) $display("FAIL basic_hi0: got %0d exp 5", hi0);
        else n_pass++;
    endtask

    task automatic test_mid_change();
        int hi0 = 0;
        for (int t = 0; t < 32 && m_k != 7; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
        end
        duty[3:0] = 4'd10;
        for (int t = 0; t < 8; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
            n_checks++;
            if (out[0] !== (1'b0 ^ INV[0])) $display("FAIL mid_keep_old t=%0d: got %b exp %b", t, out[0], INV[0]);
            else n_pass++;
        end
        for (int t = 0; t < 16; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
            if ((out[0] ^ INV[0]) === 1'b1) hi0++;
            n_checks++;
            if (out !== model_out()) $display("FAIL mid_new_out t=%0d: got %b exp %b", t, out, model_out());
            else n_pass++;
        end
        n_checks++;
        if (hi0 !== 10) $display("FAIL mid_hi0: got %0d exp 10", hi0);
        else n_pass++;
    endtask

    task automatic test_ena_slow();
        int  n_ps = 0;
        int  first_ps = -1;
        int  second_ps = -1;
        logic e;
        for (int c = 0; c < 96; c++) begin
            e = (c % 3 == 0);
            ena = e;
            tick();
            model_step(e, duty, ch_en);
            if (period_start === 1'b1) begin
                n_ps++;
                if (first_ps < 0) first_ps = c;
                else second_ps = c;
            end
            n_checks++;
            if (out !== model_out() || period_start !== m_ps)
                $display("FAIL slow c=%0d: got out=%b ps=%b exp out=%b ps=%b", c, out, period_start, model_out(), m_ps);
            else n_pass++;
        end
        n_checks++;
        if (n_ps !== 2) $display("FAIL slow_ps_count: got %0d exp 2", n_ps);
        else n_pass++;
        n_checks++;
        if (second_ps - first_ps !== 48) $display("FAIL slow_period: got %0d exp 48", second_ps - first_ps);
        else n_pass++;
        ena = 1'b1;
    endtask

    task automatic test_ch_en_clear();
        int hi2 = 0;
        for (int t = 0; t < 32 && m_k != 5; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
        end
        ch_en[2] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
            n_checks++;
            if (out !== model_out()) $display("FAIL en_old t=%0d: got %b exp %b", t, out, model_out());
            else n_pass++;
        end
        n_checks++;
        if (out[2] !== (1'b0 ^ INV[2])) $display("FAIL en_cnt15: got %b exp %b", out[2], INV[2]);
        else n_pass++;
        for (int t = 0; t < 16; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
            if ((out[2] ^ INV[2]) === 1'b1) hi2++;
        end
        n_checks++;
        if (hi2 !== 0) $display("FAIL en_cleared_hi2: got %0d exp 0", hi2);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hi0 = 0;
        for (int t = 0; t < 32 && m_k != 9; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
        end
        n_checks++;
        if (out[0] !== (1'b1 ^ INV[0])) $display("FAIL rstmid_pre: got %b exp %b", out[0], ~INV[0]);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (out !== INV) $display("FAIL rstmid_async_out: got %b exp %b", out, INV);
        else n_pass++;
        duty  = {4'd15, 4'd0, 4'd3};
        ch_en = 3'b001;
        ena   = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if (out !== INV || period_start !== 1'b0)
            $display("FAIL rstmid_sync: got out=%b ps=%b exp out=%b ps=0", out, period_start, INV);
        else n_pass++;
        ena = 1'b1;
        for (int t = 0; t < 16; t++) begin
            tick();
            model_step(1'b1, duty, ch_en);
            if ((out[0] ^ INV[0]) === 1'b1) hi0++;
            n_checks++;
            if (out !== model_out() || period_start !== (t == 0))
                $display("FAIL rstmid_run t=%0d: got out=%b ps=%b exp out=%b ps=%b", t, out, period_start, model_out(), (t == 0));
            else n_pass++;
        end
        n_checks++;
        if (hi0 !== 3) $display("FAIL rstmid_hi0: got %0d exp 3", hi0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_change();
        test_ena_slow();
        test_ch_en_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
